// File: rtl/ascon_aead128_pkg.sv
// Shared Ascon types: 320-bit state, S-box layer FSM states and the 5-bit S-box table.
package ascon_aead128_pkg;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sbox_ctrl_state_t;

    localparam logic [4:0] S_BOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

endpackage

// File: rtl/sbox.sv
// Single 5-bit Ascon column substitution; column MSB is the x0 bit.
module sbox
    import ascon_aead128_pkg::*;
(
    input  logic [4:0] x,
    output logic [4:0] y
);

    assign y = S_BOX[x];

endmodule

// File: rtl/sbox_layer_ctrl.sv
// Iterative Ascon S-box layer, LANES columns per cycle, valid/ready on both sides.
// Optional abort port enabled by defining SBOX_LAYER_CTRL_ABORT_EN.
module sbox_layer_ctrl
    import ascon_aead128_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] state_out,
`ifdef SBOX_LAYER_CTRL_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);

    localparam int NCOL = 64 / LANES;
    localparam int CW   = (NCOL > 1) ? $clog2(NCOL) : 1;

    sbox_ctrl_state_t state, state_nxt;
    logic [CW-1:0]    cnt;
    ascon_state_t     work, work_sub;
    logic             last;

    logic [5:0] col    [LANES];
    logic [4:0] col_in [LANES];
    logic [4:0] col_out[LANES];

    assign last      = (cnt == CW'(NCOL - 1));
    assign state_out = work;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign col[g]    = 6'(int'(cnt) * LANES + g);
        assign col_in[g] = {work.x0[col[g]], work.x1[col[g]],
                            work.x2[col[g]], work.x3[col[g]],
                            work.x4[col[g]]};
        sbox u_sbox (
            .x (col_in[g]),
            .y (col_out[g])
        );
    end

    always_comb begin
        work_sub = work;
        for (int j = 0; j < LANES; j++) begin
            work_sub.x0[col[j]] = col_out[j][4];
            work_sub.x1[col[j]] = col_out[j][3];
            work_sub.x2[col[j]] = col_out[j][2];
            work_sub.x3[col[j]] = col_out[j][1];
            work_sub.x4[col[j]] = col_out[j][0];
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (in_valid) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef SBOX_LAYER_CTRL_ABORT_EN
        // abort outranks the output handshake
        if (abort && state != IDLE) state_nxt = IDLE;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
        end else begin
            state <= state_nxt;
`ifdef SBOX_LAYER_CTRL_ABORT_EN
            if (abort && state != IDLE) begin
                cnt  <= '0;
                work <= '0;
            end else
`endif
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= state_in;
                        cnt  <= '0;
                    end
                end
                BUSY: begin
                    work <= work_sub;
                    cnt  <= last ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
